// File: rtl/food_placer.sv
// Food placer: samples grid candidates from the free-running coordinate
// generator, rejects cells outside the playfield or occupied by the snake,
// and commits the first free cell as the food position.
module food_placer #(
  parameter int MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] x_start_grid,
  input  logic [5:0] y_start_grid,
  input  logic [6:0] frame_x_inside_grid,
  input  logic [5:0] frame_y_inside_grid,
  input  logic [6:0] number_x_grid,
  input  logic [5:0] number_y_grid,
  input  logic       place_req,
  input  logic       food_clear,
  output logic       occ_rd,
  output logic [6:0] occ_x,
  output logic [5:0] occ_y,
  input  logic       occ_hit,
  output logic [6:0] food_x,
  output logic [5:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       place_done,
  output logic       place_fail
);

  localparam int            TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_WAIT, S_CHECK} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [6:0]    cand_x_q, cand_x_d;
  logic [5:0]    cand_y_q, cand_y_d;
  logic          occ_rd_q, occ_rd_d;
  logic [6:0]    occ_x_q, occ_x_d;
  logic [5:0]    occ_y_q, occ_y_d;
  logic [6:0]    food_x_q, food_x_d;
  logic [5:0]    food_y_q, food_y_d;
  logic          food_valid_q, food_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;

  // Upper playable limits, widened by one bit so the subtraction cannot wrap
  // once the grid is known to be larger than the frame.
  logic [7:0] lim_x, lim_y;
  logic       in_x, in_y, in_bounds;

  assign lim_x = {1'b0, number_x_grid} - {1'b0, frame_x_inside_grid} - 8'd1;
  assign lim_y = {2'b0, number_y_grid} - {2'b0, frame_y_inside_grid} - 8'd1;

  // A degenerate grid (no room inside the frame) rejects every candidate.
  assign in_x = (number_x_grid > frame_x_inside_grid)
             && (cand_x_q >= frame_x_inside_grid)
             && ({1'b0, cand_x_q} <= lim_x);
  assign in_y = (number_y_grid > frame_y_inside_grid)
             && (cand_y_q >= frame_y_inside_grid)
             && ({2'b0, cand_y_q} <= lim_y);
  assign in_bounds = in_x && in_y;

  // Next-state and registered-output logic for the placement sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    tries_d      = tries_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    occ_rd_d     = 1'b0;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;

    // A clear drops the food; a commit below in the same cycle overrides it.
    if (food_clear) food_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (place_req) begin
          state_d = S_SAMPLE;
          tries_d = '0;
        end
      end
      S_SAMPLE: begin
        cand_x_d = x_start_grid;
        cand_y_d = y_start_grid;
        occ_x_d  = x_start_grid;
        occ_y_d  = y_start_grid;
        occ_rd_d = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!occ_hit && in_bounds) begin
          food_x_d     = cand_x_q;
          food_y_d     = cand_y_q;
          food_valid_d = 1'b1;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else if (tries_q == LAST_TRY) begin
          fail_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          // The generator has moved on, so resampling yields a new candidate.
          tries_d = tries_q + 1'b1;
          state_d = S_SAMPLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tries_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      occ_rd_q     <= 1'b0;
      occ_x_q      <= '0;
      occ_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      tries_q      <= tries_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      occ_rd_q     <= occ_rd_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign occ_rd     = occ_rd_q;
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign busy       = busy_q;
  assign place_done = done_q;
  assign place_fail = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Testbench for food_placer: occupancy-map responder, output monitor and a
// scoreboard of expected placement results (kind, position, latency).
module tb_food_placer;

  localparam int MAX_TRIES = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] x_start_grid;
  logic [5:0] y_start_grid;
  logic [6:0] frame_x_inside_grid;
  logic [5:0] frame_y_inside_grid;
  logic [6:0] number_x_grid;
  logic [5:0] number_y_grid;
  logic       place_req;
  logic       food_clear;
  logic       occ_rd;
  logic [6:0] occ_x;
  logic [5:0] occ_y;
  logic       occ_hit = 1'b0;
  logic [6:0] food_x;
  logic [5:0] food_y;
  logic       food_valid;
  logic       busy;
  logic       place_done;
  logic       place_fail;

  typedef struct {
    bit         fail;
    logic [6:0] x;
    logic [5:0] y;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit   occ_map [128][64];
  bit   force_hit = 1'b0;

  int         done_cnt = 0;
  int         fail_cnt = 0;
  int         occ_rd_cycles = 0;
  logic [6:0] last_qx = '0;
  logic [5:0] last_qy = '0;

  always #5 clk = ~clk;

  food_placer #(.MAX_TRIES(MAX_TRIES)) dut (
    .clk                 (clk),
    .reset               (reset),
    .x_start_grid        (x_start_grid),
    .y_start_grid        (y_start_grid),
    .frame_x_inside_grid (frame_x_inside_grid),
    .frame_y_inside_grid (frame_y_inside_grid),
    .number_x_grid       (number_x_grid),
    .number_y_grid       (number_y_grid),
    .place_req           (place_req),
    .food_clear          (food_clear),
    .occ_rd              (occ_rd),
    .occ_x               (occ_x),
    .occ_y               (occ_y),
    .occ_hit             (occ_hit),
    .food_x              (food_x),
    .food_y              (food_y),
    .food_valid          (food_valid),
    .busy                (busy),
    .place_done          (place_done),
    .place_fail          (place_fail)
  );

  // Snake body store model: answers a query one cycle after occ_rd.
  always @(posedge clk) occ_hit <= force_hit || (occ_rd && occ_map[occ_x][occ_y]);

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (place_done) done_cnt++;
    if (place_fail) fail_cnt++;
    if (occ_rd) begin
      occ_rd_cycles++;
      last_qx = occ_x;
      last_qy = occ_y;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_map();
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < 64; j++)
        occ_map[i][j] = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that sampled the request.
  task automatic issue_req();
    place_req = 1'b1;
    @(posedge clk); #1;
    place_req = 1'b0;
  endtask

  // Observes (does not judge) the next done/fail pulse within a cycle budget.
  task automatic await_result(input int start, output bit got_done, output bit got_fail,
                              output bit got_busy, output int cyc, output bit timeout);
    cyc = start; got_done = 0; got_fail = 0; got_busy = 0; timeout = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (place_done || place_fail) begin
        got_done = place_done; got_fail = place_fail; got_busy = busy; timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int d0, f0;
    reset = 1'b1;
    #12;
    n_checks++;
    if ({occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, place_done, place_fail} !== '0) begin
      n_fail++; $display("FAIL reset_init: outputs not all zero");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    x_start_grid = 7'd30; y_start_grid = 6'd15;
    issue_req();
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1 || occ_rd !== 1'b1) begin
      n_fail++; $display("FAIL reset_prerun: busy=%b occ_rd=%b expected 1/1", busy, occ_rd);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({occ_rd, occ_x, occ_y, food_x, food_y, food_valid, busy, place_done, place_fail} !== '0) begin
      n_fail++; $display("FAIL reset_async: outputs not zero during reset, occ_x=%0d busy=%b", occ_x, busy);
    end
    d0 = done_cnt; f0 = fail_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 || fail_cnt != f0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_abandon: done=%0d fail=%0d busy=%b expected no pulses, idle", done_cnt - d0, fail_cnt - f0, busy);
    end
  endtask

  task automatic test_first_try();
    bit gd, gf, gb, to; int cyc, q0; exp_t e;
    x_start_grid = 7'd30; y_start_grid = 6'd15;
    q0 = occ_rd_cycles;
    issue_req();
    exp_q.push_back('{0, 7'd30, 6'd15, 3});
    await_result(0, gd, gf, gb, cyc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || gd !== !e.fail || gf !== e.fail || cyc != e.lat) begin
      n_fail++; $display("FAIL first_try_pulse: done=%b fail=%b cyc=%0d expected done at %0d", gd, gf, cyc, e.lat);
    end
    n_checks++;
    if (food_x !== e.x || food_y !== e.y || food_valid !== 1'b1 || gb !== 1'b0) begin
      n_fail++; $display("FAIL first_try_food: (%0d,%0d) v=%b busy=%b expected (%0d,%0d) v=1 busy=0", food_x, food_y, food_valid, gb, e.x, e.y);
    end
    n_checks++;
    if (occ_rd_cycles - q0 != 1 || last_qx !== 7'd30 || last_qy !== 6'd15) begin
      n_fail++; $display("FAIL first_try_query: %0d cycles at (%0d,%0d) expected 1 at (30,15)", occ_rd_cycles - q0, last_qx, last_qy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (place_done !== 1'b0) begin
      n_fail++; $display("FAIL first_try_single: place_done=%b expected 0", place_done);
    end
  endtask

  task automatic test_retry();
    bit gd, gf, gb, to; int cyc, q0; exp_t e;
    occ_map[30][15] = 1'b1;
    x_start_grid = 7'd30; y_start_grid = 6'd15;
    q0 = occ_rd_cycles;
    issue_req();
    exp_q.push_back('{0, 7'd31, 6'd14, 6});
    @(posedge clk); #1;
    x_start_grid = 7'd31; y_start_grid = 6'd14;
    await_result(1, gd, gf, gb, cyc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || gd !== 1'b1 || cyc != e.lat) begin
      n_fail++; $display("FAIL retry_pulse: done=%b cyc=%0d expected done at %0d", gd, cyc, e.lat);
    end
    n_checks++;
    if (food_x !== e.x || food_y !== e.y || occ_rd_cycles - q0 != 2) begin
      n_fail++; $display("FAIL retry_food: (%0d,%0d) queries=%0d expected (%0d,%0d) queries=2", food_x, food_y, occ_rd_cycles - q0, e.x, e.y);
    end
    clear_map();
  endtask

  task automatic test_fail();
    bit gd, gf, gb, to; int cyc; exp_t e;
    force_hit = 1'b1;
    x_start_grid = 7'd50; y_start_grid = 6'd40;
    issue_req();
    exp_q.push_back('{1, 7'd31, 6'd14, 3 * MAX_TRIES});
    await_result(0, gd, gf, gb, cyc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || gf !== 1'b1 || gd !== 1'b0 || cyc != e.lat || gb !== 1'b0) begin
      n_fail++; $display("FAIL exhaust_pulse: fail=%b done=%b cyc=%0d busy=%b expected fail at %0d", gf, gd, cyc, gb, e.lat);
    end
    n_checks++;
    if (food_x !== e.x || food_y !== e.y || food_valid !== 1'b1) begin
      n_fail++; $display("FAIL exhaust_food: (%0d,%0d) v=%b expected (%0d,%0d) v=1", food_x, food_y, food_valid, e.x, e.y);
    end
    force_hit = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bounds();
    bit gd, gf, gb, to; int cyc; exp_t e;
    logic [6:0] tx [6] = '{7'd1, 7'd78, 7'd0, 7'd79, 7'd10, 7'd10};
    logic [5:0] ty [6] = '{6'd1, 6'd58, 6'd10, 6'd10, 6'd0, 6'd59};
    bit         ok [6] = '{1, 1, 0, 0, 0, 0};
    for (int k = 0; k < 6; k++) begin
      x_start_grid = tx[k]; y_start_grid = ty[k];
      issue_req();
      if (ok[k]) exp_q.push_back('{0, tx[k], ty[k], 3});
      else       exp_q.push_back('{0, 7'd40, 6'd30, 6});
      @(posedge clk); #1;
      x_start_grid = 7'd40; y_start_grid = 6'd30;
      await_result(1, gd, gf, gb, cyc, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || gd !== 1'b1 || cyc != e.lat || food_x !== e.x || food_y !== e.y) begin
        n_fail++; $display("FAIL bounds_%0d: done=%b cyc=%0d food=(%0d,%0d) expected cyc %0d food=(%0d,%0d)", k, gd, cyc, food_x, food_y, e.lat, e.x, e.y);
      end
    end
    number_x_grid = 7'd2;
    x_start_grid = 7'd1; y_start_grid = 6'd30;
    issue_req();
    exp_q.push_back('{1, 7'd40, 6'd30, 3 * MAX_TRIES});
    await_result(0, gd, gf, gb, cyc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || gf !== 1'b1 || cyc != e.lat || food_x !== e.x || food_y !== e.y || food_valid !== 1'b1) begin
      n_fail++; $display("FAIL degenerate_grid: fail=%b cyc=%0d food=(%0d,%0d) expected fail at %0d food=(%0d,%0d)", gf, cyc, food_x, food_y, e.lat, e.x, e.y);
    end
    number_x_grid = 7'd80;
  endtask

  task automatic test_back_to_back();
    bit gd, gf, gb, to; int cyc, d0; exp_t e;
    x_start_grid = 7'd20; y_start_grid = 6'd20;
    d0 = done_cnt;
    issue_req();
    exp_q.push_back('{0, 7'd20, 6'd20, 3});
    @(posedge clk); #1;
    place_req = 1'b1;
    @(posedge clk); #1;
    place_req = 1'b0;
    await_result(2, gd, gf, gb, cyc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || gd !== 1'b1 || cyc != e.lat || food_x !== e.x || food_y !== e.y) begin
      n_fail++; $display("FAIL busy_req_first: done=%b cyc=%0d food=(%0d,%0d) expected cyc %0d food=(%0d,%0d)", gd, cyc, food_x, food_y, e.lat, e.x, e.y);
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_req_ignored: %0d done pulses busy=%b expected 1 pulse, idle", done_cnt - d0, busy);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    food_clear = 1'b1;
    @(posedge clk); #1;
    food_clear = 1'b0;
    n_checks++;
    if (food_valid !== 1'b0 || food_x !== 7'd20 || food_y !== 6'd20) begin
      n_fail++; $display("FAIL clear_alone: v=%b food=(%0d,%0d) expected v=0 food=(20,20)", food_valid, food_x, food_y);
    end
    x_start_grid = 7'd25; y_start_grid = 6'd25;
    issue_req();
    exp_q.push_back('{0, 7'd25, 6'd25, 3});
    repeat (2) @(posedge clk);
    #1;
    food_clear = 1'b1;
    @(posedge clk); #1;
    food_clear = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (place_done !== 1'b1 || food_valid !== 1'b1 || food_x !== e.x || food_y !== e.y) begin
      n_fail++; $display("FAIL clear_vs_commit: done=%b v=%b food=(%0d,%0d) expected done=1 v=1 food=(%0d,%0d)", place_done, food_valid, food_x, food_y, e.x, e.y);
    end
    food_clear = 1'b1;
    #3;
    n_checks++;
    if (food_valid !== 1'b1) begin
      n_fail++; $display("FAIL clear_timing: v=%b before edge expected 1", food_valid);
    end
    @(posedge clk); #1;
    food_clear = 1'b0;
    n_checks++;
    if (food_valid !== 1'b0 || food_x !== 7'd25) begin
      n_fail++; $display("FAIL clear_after_commit: v=%b x=%0d expected v=0 x=25", food_valid, food_x);
    end
  endtask

  initial begin
    reset = 1'b1;
    place_req = 1'b0;
    food_clear = 1'b0;
    x_start_grid = '0; y_start_grid = '0;
    frame_x_inside_grid = 7'd1; frame_y_inside_grid = 6'd1;
    number_x_grid = 7'd80; number_y_grid = 6'd60;
    clear_map();
    test_reset();
    test_first_try();
    test_retry();
    test_fail();
    test_bounds();
    test_back_to_back();
    test_clear();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
